core_requester: RTL

CORE_REQUESTER -- requirements
Module: core_requester

---
 rtl/core_requester.sv | 132 +++++++++++++
 1 files changed

// File: rtl/core_requester.sv
// Handshake front-end for a multi-cycle arithmetic core: captures an operand pair,
// pulses start, waits for done or a cycle timeout, then hands the result off.
module core_requester #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] Zahl1_i,
    input  logic [WIDTH-1:0] Zahl2_i,
    output logic             start_o,
    output logic [WIDTH-1:0] Zahl1_o,
    output logic [WIDTH-1:0] Zahl2_o,
    input  logic [WIDTH-1:0] ergebnis_i,
    input  logic             done_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] ergebnis_o,
    output logic             timeout_o,
    output logic [15:0]      jobs_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam int unsigned CNT_W = 16;
    // Counter value of the last WAIT cycle; done in that cycle still wins.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] zahl1_q, zahl1_d;
    logic [WIDTH-1:0] zahl2_q, zahl2_d;
    logic [WIDTH-1:0] erg_q, erg_d;
    logic             timeout_q, timeout_d;
    logic             start_q, start_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [15:0]      jobs_q, jobs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            zahl1_q     <= '0;
            zahl2_q     <= '0;
            erg_q       <= '0;
            timeout_q   <= 1'b0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            jobs_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            zahl1_q     <= zahl1_d;
            zahl2_q     <= zahl2_d;
            erg_q       <= erg_d;
            timeout_q   <= timeout_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            jobs_q      <= jobs_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        zahl1_d     = zahl1_q;
        zahl2_d     = zahl2_q;
        erg_d       = erg_q;
        timeout_d   = timeout_q;
        jobs_d      = jobs_q;
        start_d     = 1'b0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    zahl1_d = Zahl1_i;
                    zahl2_d = Zahl2_i;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_i) begin
                    erg_d     = ergebnis_i;
                    timeout_d = 1'b0;
                    state_d   = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    erg_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (out_ready_i) begin
                    jobs_d  = jobs_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered decodes of the next state.
        start_d     = (state_d == S_START);
        out_valid_d = (state_d == S_HOLD);
        in_ready_d  = (state_d == S_IDLE);
    end

    assign in_ready_o  = in_ready_q;
    assign start_o     = start_q;
    assign Zahl1_o     = zahl1_q;
    assign Zahl2_o     = zahl2_q;
    assign out_valid_o = out_valid_q;
    assign ergebnis_o  = erg_q;
    assign timeout_o   = timeout_q;
    assign jobs_o      = jobs_q;

endmodule
